// File: rtl/fiat_25519_pkg.sv
// Shared constants, state encoding and limb-width helper for the fiat_25519
// column accumulation datapath.
package fiat_25519_pkg;

    localparam int unsigned NUM_LIMBS = 10;
    localparam int unsigned PROD_W    = 64;
    localparam int unsigned ACC_W     = 72;
    localparam int unsigned LIMB_W    = 26;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned CARRY_W   = ACC_W - (LIMB_W - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_e;

    // Radix 2^25.5: even limbs carry 26 bits, odd limbs 25.
    function automatic int unsigned limb_width(input logic [IDX_W-1:0] idx);
        return ((idx & IDX_W'(1)) != '0) ? LIMB_W - 1 : LIMB_W;
    endfunction

endpackage

// File: rtl/fiat_25519_column_accumulator_if.sv
// Product-in / limb-out handshake bundle of the column accumulator.
interface fiat_25519_column_accumulator_if;
    import fiat_25519_pkg::*;

    logic                prod_valid;
    logic [PROD_W-1:0]   prod_data;
    logic                prod_last;
    logic                prod_ready;

    logic                limb_valid;
    logic [LIMB_W-1:0]   limb_data;
    logic [IDX_W-1:0]    limb_idx;
    logic                limb_ready;
    logic                frame_done;
    logic [CARRY_W-1:0]  carry_out;

    modport slave (
        input  prod_valid, prod_data, prod_last, limb_ready,
        output prod_ready, limb_valid, limb_data, limb_idx, frame_done, carry_out
    );

    modport master (
        output prod_valid, prod_data, prod_last, limb_ready,
        input  prod_ready, limb_valid, limb_data, limb_idx, frame_done, carry_out
    );

endinterface

// File: rtl/fiat_25519_limb_split.sv
// Splits a column sum into its radix-2^25.5 limb and the carry into the next column.
module fiat_25519_limb_split
    import fiat_25519_pkg::*;
(
    input  logic [ACC_W-1:0]   nxt,
    input  logic               odd,
    output logic [LIMB_W-1:0]  limb,
    output logic [CARRY_W-1:0] carry
);

    int unsigned      w;
    logic [ACC_W-1:0] mask;
    logic [ACC_W-1:0] low;
    logic [ACC_W-1:0] shifted;

    always_comb begin
        w       = limb_width(IDX_W'(odd));
        mask    = (ACC_W'(1) << w) - ACC_W'(1);
        low     = nxt & mask;
        shifted = nxt >> w;
        limb    = LIMB_W'(low);
        carry   = CARRY_W'(shifted);
    end

endmodule

// File: rtl/fiat_25519_column_accumulator.sv
// Sums product beats per limb column with carry-in and emits one reduced limb
// per column; the top carry of limb 9 is exposed for the x19 fold stage.
module fiat_25519_column_accumulator
    import fiat_25519_pkg::*;
(
    input  logic ap_clk,
    input  logic ap_rst_n,
    fiat_25519_column_accumulator_if.slave bus
);

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CARRY_W-1:0]   carry_q, carry_d;
    logic [LIMB_W-1:0]    limb_data_q, limb_data_d;
    logic [IDX_W-1:0]     limb_idx_q, limb_idx_d;
    logic [CARRY_W-1:0]   carry_out_q, carry_out_d;
    logic                 frame_done_q, frame_done_d;
    logic                 limb_valid_q, limb_valid_d;
    logic                 prod_ready_q, prod_ready_d;

    logic                 accept;
    logic                 emit_hs;
    logic                 last_idx;
    logic [ACC_W-1:0]     nxt;
    logic [LIMB_W-1:0]    split_limb;
    logic [CARRY_W-1:0]   split_carry;

    assign accept   = bus.prod_valid && prod_ready_q;
    assign emit_hs  = (state_q == ST_EMIT) && bus.limb_ready;
    assign last_idx = (limb_idx_q == IDX_W'(NUM_LIMBS - 1));
    assign nxt      = acc_q + ACC_W'(bus.prod_data);

    fiat_25519_limb_split u_split (
        .nxt   (nxt),
        .odd   (limb_idx_q[0]),
        .limb  (split_limb),
        .carry (split_carry)
    );

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (accept && bus.prod_last) state_d = ST_EMIT;
            ST_EMIT:  if (bus.limb_ready)          state_d = ST_ACCUM;
            default:                               state_d = ST_ACCUM;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        acc_d        = acc_q;
        carry_d      = carry_q;
        limb_data_d  = limb_data_q;
        limb_idx_d   = limb_idx_q;
        carry_out_d  = carry_out_q;
        frame_done_d = frame_done_q;
        prod_ready_d = (state_d == ST_ACCUM);
        limb_valid_d = (state_d == ST_EMIT);

        if ((state_q == ST_ACCUM) && accept) begin
            acc_d = nxt;
            if (bus.prod_last) begin
                limb_data_d  = split_limb;
                carry_d      = split_carry;
                frame_done_d = last_idx;
                carry_out_d  = last_idx ? split_carry : '0;
            end
        end

        // Handshake hands the carry into the next column; frame wrap drops it.
        if (emit_hs) begin
            frame_done_d = 1'b0;
            if (last_idx) begin
                acc_d      = '0;
                limb_idx_d = '0;
            end else begin
                acc_d      = ACC_W'(carry_q);
                limb_idx_d = limb_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q        <= '0;
            carry_q      <= '0;
            limb_data_q  <= '0;
            limb_idx_q   <= '0;
            carry_out_q  <= '0;
            frame_done_q <= 1'b0;
            limb_valid_q <= 1'b0;
            prod_ready_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            carry_q      <= carry_d;
            limb_data_q  <= limb_data_d;
            limb_idx_q   <= limb_idx_d;
            carry_out_q  <= carry_out_d;
            frame_done_q <= frame_done_d;
            limb_valid_q <= limb_valid_d;
            prod_ready_q <= prod_ready_d;
        end
    end

    assign bus.prod_ready = prod_ready_q;
    assign bus.limb_valid = limb_valid_q;
    assign bus.limb_data  = limb_data_q;
    assign bus.limb_idx   = limb_idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.carry_out  = carry_out_q;

endmodule

// File: tb/tb_fiat_25519_column_accumulator.sv
// Scoreboard bench for the column accumulator: arithmetic reference model feeds an
// expectation queue that a negedge monitor drains on every limb handshake.
module tb_fiat_25519_column_accumulator;
    import fiat_25519_pkg::*;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    fiat_25519_column_accumulator_if bus();

    fiat_25519_column_accumulator dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    logic [ACC_W-1:0]   s_nxt;
    logic               s_odd;
    logic [LIMB_W-1:0]  s_limb;
    logic [CARRY_W-1:0] s_carry;

    fiat_25519_limb_split u_split_chk (
        .nxt   (s_nxt),
        .odd   (s_odd),
        .limb  (s_limb),
        .carry (s_carry)
    );

    typedef struct {
        logic [IDX_W-1:0]   idx;
        logic [LIMB_W-1:0]  data;
        logic               fd;
        logic [CARRY_W-1:0] co;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    logic [63:0]    cq[$];
    int             checks = 0;
    int             errors = 0;
    int             hs_count = 0;
    int             cyc = 0;
    int             prev_cyc = 0;
    bit             have_prev = 0;
    bit             thr_mode = 0;
    bit             rand_ready = 0;
    logic [LIMB_W-1:0] last_data = '0;

    logic [127:0]   m_carry = '0;
    int             m_idx = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: column sum = carry-in + beats; limb = sum mod 2^w, carry = sum / 2^w.
    task automatic model_column(input logic [127:0] col_sum);
        logic [127:0] sum;
        logic [127:0] pw;
        int w;
        exp_t e;
        sum = m_carry + col_sum;
        checks++;
        if (sum >= (128'(1) << 69)) begin
            errors++;
            $display("FAIL column_range: sum 0x%0h exceeds legal bound", sum);
        end
        w = (m_idx % 2 == 0) ? 26 : 25;
        pw = 128'(1) << w;
        e.idx  = IDX_W'(m_idx);
        e.data = LIMB_W'(sum % pw);
        e.fd   = (m_idx == NUM_LIMBS - 1);
        e.co   = CARRY_W'(sum / pw);
        exp_q.push_back(e);
        if (e.fd) begin
            m_carry = '0;
            m_idx   = 0;
        end else begin
            m_carry = sum / pw;
            m_idx++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.prod_ready && n < 1000) begin
            @(posedge ap_clk); #1;
            n++;
        end
        if (!bus.prod_ready) begin
            checks++; errors++;
            $display("FAIL prod_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic send_column(input logic [63:0] beats[$], input bit hold);
        logic [127:0] s = '0;
        for (int i = 0; i < beats.size(); i++) begin
            @(posedge ap_clk); #1;
            bus.prod_valid = 1'b1;
            bus.prod_data  = beats[i];
            bus.prod_last  = (i == beats.size() - 1);
            wait_ready();
            s = s + 128'(beats[i]);
            if (i == beats.size() - 1) model_column(s);
        end
        if (!hold) begin
            @(posedge ap_clk); #1;
            bus.prod_valid = 1'b0;
            bus.prod_last  = 1'b0;
        end
    endtask

    task automatic send1(input logic [63:0] b, input bit hold);
        cq = {};
        cq.push_back(b);
        send_column(cq, hold);
    endtask

    task automatic send_random(input int max_beats, input bit hold);
        int n;
        n = $urandom_range(1, max_beats);
        cq = {};
        for (int i = 0; i < n; i++) cq.push_back({$urandom, $urandom});
        send_column(cq, hold);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge ap_clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_prod_ready", bus.prod_ready, 0);
        check("rst_limb_valid", bus.limb_valid, 0);
        check("rst_limb_data",  bus.limb_data, 0);
        check("rst_limb_idx",   bus.limb_idx, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_carry_out",  bus.carry_out, 0);
    endtask

    // Monitor: every limb handshake pops one expectation.
    always @(negedge ap_clk) begin
        if (ap_rst_n && bus.limb_valid && bus.limb_ready) begin
            hs_count++;
            last_data = bus.limb_data;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_limb: got idx %0d data 0x%0h expected none",
                         bus.limb_idx, bus.limb_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("limb_idx",   bus.limb_idx,   mon_e.idx);
                check("limb_data",  bus.limb_data,  mon_e.data);
                check("frame_done", bus.frame_done, mon_e.fd);
                if (mon_e.fd) check("carry_out", bus.carry_out, mon_e.co);
            end
            if (thr_mode && have_prev) check("limb_spacing", 128'(cyc - prev_cyc), 2);
            prev_cyc  = cyc;
            have_prev = 1;
        end
    end

    always @(posedge ap_clk) begin
        #1;
        if (rand_ready) bus.limb_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hs_before;
        bus.prod_valid = 1'b0;
        bus.prod_data  = '0;
        bus.prod_last  = 1'b0;
        bus.limb_ready = 1'b1;

        // Reset state and prod_ready release timing
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check_reset_outputs();
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("ready_before_sample", bus.prod_ready, 0);
        @(negedge ap_clk);
        check("ready_after_release", bus.prod_ready, 1);

        // Carry ripple columns 0..2
        cq = {};
        cq.push_back(64'h3FFFFFF);
        cq.push_back(64'h1);
        send_column(cq, 0);
        wait_drain();
        check("col0_limb", last_data, 0);
        send1(64'h1FFFFFF, 0);
        wait_drain();
        check("col1_limb", last_data, 0);
        send1(64'h0, 0);
        wait_drain();
        check("col2_limb", last_data, 1);
        for (int c = 3; c < NUM_LIMBS; c++) send_random(3, 0);
        wait_drain();

        // All-ones frame, then fresh frame without carry-in
        for (int c = 0; c < NUM_LIMBS; c++) send1(64'hFFFF_FFFF_FFFF_FFFF, 0);
        wait_drain();
        send1(64'h5, 0);
        wait_drain();
        check("new_frame_limb0", last_data, 5);
        for (int c = 1; c < NUM_LIMBS; c++) send_random(2, 0);
        wait_drain();

        // Backpressure on column 2 with the next beat already pending
        send_random(2, 0);
        send_random(2, 0);
        wait_drain();
        bus.limb_ready = 1'b0;
        send_random(3, 0);
        @(posedge ap_clk); #1;
        bus.prod_valid = 1'b1;
        bus.prod_data  = 64'h0123_4567_89AB_CDEF;
        bus.prod_last  = 1'b1;
        hs_before = hs_count;
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            check("stall_prod_ready", bus.prod_ready, 0);
            check("stall_limb_valid", bus.limb_valid, 1);
            check("stall_limb_idx",   bus.limb_idx, exp_q[0].idx);
            check("stall_limb_data",  bus.limb_data, exp_q[0].data);
        end
        @(posedge ap_clk); #1;
        bus.limb_ready = 1'b1;
        send1(64'h0123_4567_89AB_CDEF, 0);
        @(negedge ap_clk);
        check("stall_release_hs", hs_count - hs_before, 1);
        wait_drain();

        // Reset after three beats of column 4
        for (int i = 0; i < 3; i++) begin
            @(posedge ap_clk); #1;
            bus.prod_valid = 1'b1;
            bus.prod_data  = {$urandom, $urandom};
            bus.prod_last  = 1'b0;
            wait_ready();
        end
        @(posedge ap_clk); #1;
        bus.prod_valid = 1'b0;
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        @(negedge ap_clk);
        check_reset_outputs();
        check("rst_no_pending", exp_q.size(), 0);
        m_carry = '0;
        m_idx   = 0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        send1(64'h7, 0);
        wait_drain();
        check("post_rst_limb0", last_data, 7);

        // Back-to-back single-beat columns, prod_valid held high
        have_prev = 0;
        thr_mode  = 1;
        for (int c = 1; c < NUM_LIMBS; c++) send1({$urandom, $urandom}, c != NUM_LIMBS - 1);
        wait_drain();
        thr_mode = 0;

        // Randomised frames with random downstream backpressure and idle gaps
        rand_ready = 1;
        for (int c = 0; c < 3 * NUM_LIMBS; c++) begin
            send_random(4, 0);
            repeat ($urandom_range(0, 2)) @(posedge ap_clk);
        end
        wait_drain();
        rand_ready = 0;
        @(posedge ap_clk); #1;
        bus.limb_ready = 1'b1;

        // Standalone limb split
        for (int i = 0; i < 8; i++) begin
            logic [127:0] pw;
            s_nxt = {8'($urandom), $urandom, $urandom};
            s_odd = 1'(i % 2);
            #1;
            pw = 128'(1) << (s_odd ? 25 : 26);
            check("split_limb",  s_limb,  128'(s_nxt) % pw);
            check("split_carry", s_carry, 128'(s_nxt) / pw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
